// File: rtl/line_tracker_fsm.sv
// Line-follower steering controller: samples the sensor array once per
// control period, derives a signed position error and drives both motor
// channels (enable, direction, duty) with lost-line search/stop recovery.
module line_tracker_fsm #(
  parameter int NUM_SENSORS  = 5,
  parameter int CNT_WIDTH    = 21,
  parameter int PERIOD       = 2000000,
  parameter int SHARP_TH     = 2,
  parameter int LOST_PERIODS = 25,
  parameter int DUTY_WIDTH   = 8,
  parameter int FULL_DUTY    = 255,
  parameter int TURN_DUTY    = 160,
  parameter int SEARCH_DUTY  = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic [CNT_WIDTH-1:0]   count_in,
  output logic                   count_reset,
  output logic                   motor_l_reset,
  output logic                   motor_l_direction,
  output logic [DUTY_WIDTH-1:0]  motor_l_duty,
  output logic                   motor_r_reset,
  output logic                   motor_r_direction,
  output logic [DUTY_WIDTH-1:0]  motor_r_duty,
  output logic [2:0]             state_out,
  output logic                   lost
);

  localparam int CENTER = (NUM_SENSORS - 1) / 2;
  localparam int ERR_W  = $clog2(NUM_SENSORS * NUM_SENSORS) + 1;
  localparam int LOST_W = $clog2(LOST_PERIODS + 1);

  localparam logic [CNT_WIDTH-1:0]  TICK_AT  = CNT_WIDTH'(PERIOD - 1);
  localparam logic [LOST_W-1:0]     LOST_MAX = LOST_W'(LOST_PERIODS - 1);
  localparam logic [DUTY_WIDTH-1:0] D_FULL   = DUTY_WIDTH'(FULL_DUTY);
  localparam logic [DUTY_WIDTH-1:0] D_TURN   = DUTY_WIDTH'(TURN_DUTY);
  localparam logic [DUTY_WIDTH-1:0] D_SEARCH = DUTY_WIDTH'(SEARCH_DUTY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FORWARD  = 3'd1,
    S_GENTLE_L = 3'd2,
    S_SHARP_L  = 3'd3,
    S_GENTLE_R = 3'd4,
    S_SHARP_R  = 3'd5,
    S_SEARCH   = 3'd6,
    S_STOP     = 3'd7
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  state_e                   r_state;
  state_e                   w_next;
  logic                     r_count_reset;
  logic [LOST_W-1:0]        r_lost_cnt;
  logic [LOST_W-1:0]        w_lost_next;
  dir_e                     r_last_dir;
  dir_e                     w_dir_next;
  logic                     w_tick;
  logic                     w_any;
  logic signed [ERR_W-1:0]  w_err;

  // The cycle after a tick has count_reset high, which masks a second tick
  // while the counter is still at or above the threshold.
  assign w_tick = (count_in >= TICK_AT) && !r_count_reset;
  assign w_any  = |sensors;

  // Signed position error: each active sensor contributes its offset from centre.
  always_comb begin
    int v_sum;
    v_sum = 0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (sensors[i]) v_sum = v_sum + (int'(i) - CENTER);
    end
    w_err = ERR_W'(v_sum);
  end

  // State, lost counter, last-seen side and period-counter clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_count_reset <= 1'b1;
      r_lost_cnt    <= '0;
      r_last_dir    <= DIR_LEFT;
    end else begin
      r_count_reset <= w_tick;
      if (w_tick) begin
        r_state    <= w_next;
        r_lost_cnt <= w_lost_next;
        r_last_dir <= w_dir_next;
      end
    end
  end

  // Next-state, lost counter and last-seen side as evaluated at a tick.
  always_comb begin
    int v_err;
    w_next      = r_state;
    w_lost_next = r_lost_cnt;
    w_dir_next  = r_last_dir;
    v_err       = int'(w_err);
    if (w_any) begin
      w_lost_next = '0;
      if (v_err == 0) begin
        w_next = S_FORWARD;
      end else if (v_err > 0) begin
        w_dir_next = DIR_LEFT;
        w_next     = (v_err >= SHARP_TH) ? S_SHARP_L : S_GENTLE_L;
      end else begin
        w_dir_next = DIR_RIGHT;
        w_next     = (-v_err >= SHARP_TH) ? S_SHARP_R : S_GENTLE_R;
      end
    end else if (r_state == S_IDLE || r_state == S_STOP) begin
      w_next = S_STOP;
    end else if (r_lost_cnt < LOST_MAX) begin
      w_next      = S_SEARCH;
      w_lost_next = r_lost_cnt + LOST_W'(1);
    end else begin
      w_next = S_STOP;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    motor_l_reset     = 1'b1;
    motor_l_direction = 1'b0;
    motor_l_duty      = '0;
    motor_r_reset     = 1'b1;
    motor_r_direction = 1'b0;
    motor_r_duty      = '0;
    unique case (r_state)
      S_FORWARD: begin
        motor_l_reset     = 1'b0;
        motor_l_direction = 1'b1;
        motor_r_reset     = 1'b0;
        motor_l_duty      = D_FULL;
        motor_r_duty      = D_FULL;
      end
      S_GENTLE_L: begin
        motor_r_reset = 1'b0;
        motor_r_duty  = D_TURN;
      end
      S_SHARP_L: begin
        motor_l_reset = 1'b0;
        motor_r_reset = 1'b0;
        motor_l_duty  = D_TURN;
        motor_r_duty  = D_TURN;
      end
      S_GENTLE_R: begin
        motor_l_reset     = 1'b0;
        motor_l_direction = 1'b1;
        motor_l_duty      = D_TURN;
      end
      S_SHARP_R: begin
        motor_l_reset     = 1'b0;
        motor_l_direction = 1'b1;
        motor_r_reset     = 1'b0;
        motor_r_direction = 1'b1;
        motor_l_duty      = D_TURN;
        motor_r_duty      = D_TURN;
      end
      S_SEARCH: begin
        motor_l_reset = 1'b0;
        motor_r_reset = 1'b0;
        motor_l_duty  = D_SEARCH;
        motor_r_duty  = D_SEARCH;
        if (r_last_dir == DIR_RIGHT) begin
          motor_l_direction = 1'b1;
          motor_r_direction = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign count_reset = r_count_reset;
  assign state_out   = r_state;
  assign lost        = (r_state == S_SEARCH) || (r_state == S_STOP);

endmodule

// File: doc/line_tracker_fsm.md
Name: line_tracker_fsm

Overview:
- Parametrised steering controller for the line follower.
- Samples an N-wide sensor array once per control period and computes a signed position error.
- Selects forward, gentle, sharp or search steering, and drives both motor channels with enable, direction and a duty level for the PWM stage.
- Adds lost-line recovery (search towards the last-seen side, then stop) on top of plain steering.
- Sits between the sensor synchroniser and the two motor PWM blocks, and shares the external free-running period counter.

Parameters:
NUM_SENSORS, 5, sensor count; odd, >=3; bit NUM_SENSORS-1 = leftmost, bit 0 = rightmost
CNT_WIDTH, 21, width of count_in
PERIOD, 2000000, control period in clk cycles (tick threshold)
SHARP_TH, 2, |err| >= SHARP_TH selects sharp turn, otherwise gentle
LOST_PERIODS, 25, consecutive empty periods in SEARCH before STOP; >=1
DUTY_WIDTH, 8, width of duty outputs
FULL_DUTY, 255, duty for FORWARD
TURN_DUTY, 160, duty for running motor(s) in gentle/sharp turns
SEARCH_DUTY, 96, duty for both motors in SEARCH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
sensors  in  NUM_SENSORS  1 = line under sensor; already synchronised
count_in  in  CNT_WIDTH  external period counter; counts up, clears synchronously while count_reset=1
count_reset  out  1  registered clear for the period counter
motor_l_reset  out  1  1 = left motor disabled
motor_l_direction  out  1  left motor direction (1 = forward)
motor_l_duty  out  DUTY_WIDTH  left PWM duty
motor_r_reset  out  1  1 = right motor disabled
motor_r_direction  out  1  right motor direction (0 = forward, mirror-mounted)
motor_r_duty  out  DUTY_WIDTH  right PWM duty
state_out  out  3  current state encoding
lost  out  1  1 while in SEARCH or STOP

Behaviour:
- Reset
  - reset=0 sampled at a clk edge: state<=IDLE, count_reset<=1, lost_cnt<=0, last_dir<=LEFT.
  - Outputs in IDLE: both motor resets 1, directions 0, duties 0, lost 0.
- Tick
  - tick = (count_in >= PERIOD-1) && !count_reset.
  - On a tick edge: count_reset<=1 for exactly one cycle, and the state register updates.
  - Otherwise count_reset<=0.
  - Effective period = PERIOD+1 cycles.
- Sampling: sensors are evaluated only on tick cycles; changes between ticks are ignored.
- Error
  - C = (NUM_SENSORS-1)/2; err = signed sum of (i-C) over active bits i.
  - Width $clog2(NUM_SENSORS*NUM_SENSORS)+1, no overflow possible.
  - err>0 = line left of centre.
- Next-state on tick, in priority order:
  1. any sensor active and err==0 -> FORWARD; includes all-active and symmetric patterns.
  2. err>0 -> SHARP_L if err>=SHARP_TH, else GENTLE_L.
  3. err<0 -> SHARP_R if -err>=SHARP_TH, else GENTLE_R.
  4. no sensor active:
     - from IDLE -> STOP.
     - from STOP -> STOP.
     - otherwise -> SEARCH while lost_cnt < LOST_PERIODS-1 (lost_cnt++); when lost_cnt == LOST_PERIODS-1 -> STOP.
- Counters on tick:
  - any active sensor clears lost_cnt.
  - err>0 sets last_dir=LEFT; err<0 sets last_dir=RIGHT; err==0 holds last_dir.
- Encoding: IDLE=0, FORWARD=1, GENTLE_L=2, SHARP_L=3, GENTLE_R=4, SHARP_R=5, SEARCH=6, STOP=7.
- Outputs (Moore, decoded from the registered state), listed as l_reset/l_dir/r_reset/r_dir, duty:
  - FORWARD: 0/1/0/0, both FULL_DUTY.
  - GENTLE_L: 1/0/0/0, l_duty 0, r_duty TURN_DUTY.
  - SHARP_L: 0/0/0/0, both TURN_DUTY.
  - GENTLE_R: 0/1/1/0, l_duty TURN_DUTY, r_duty 0.
  - SHARP_R: 0/1/0/1, both TURN_DUTY.
  - SEARCH: pivot towards last_dir; LEFT as SHARP_L, RIGHT as SHARP_R; both SEARCH_DUTY.
  - IDLE, STOP: resets 1, directions 0, duties 0.
- Latency: outputs reflect the sensors sampled at a tick from the cycle after that tick edge, held for the full period.
- Mid-operation reset: reset=0 in any state returns everything to reset values at the next edge, regardless of tick.
- Exiting STOP: any active sensor at a tick resumes normal steering.

Test Plan:
Common bench settings: NUM_SENSORS=5, PERIOD=16, LOST_PERIODS=4, SHARP_TH=2; counter model per port spec.
1. Hold reset=0 for 3 cycles with sensors=00100 -> count_reset=1, state_out=0, both motor resets 1, duties 0. Release reset -> IDLE until first tick, then state_out=1 with duties 255/255 and directions l=1, r=0.
2. sensors=01000 at tick -> GENTLE_L (2): l_reset=1, r_duty=160. sensors=10000 -> SHARP_L (3), both duties 160. sensors=00011 (err=-3) -> SHARP_R (5), l_dir=1, r_dir=1.
3. In FORWARD, switch sensors to 00001 at count 5 and back to 00100 at count 10 -> state stays FORWARD; count_reset pulses exactly once per 17 cycles.
4. From GENTLE_R, sensors=00000 -> SEARCH (6), lost=1, pivot right (l_dir=1, r_dir=1), duties 96. State stays SEARCH for ticks 1-3 and goes to STOP (7) on tick 4. sensors=00100 on the next tick -> FORWARD, lost=0.
5. sensors=11111, then 10001 -> FORWARD both times, with last_dir unchanged.
6. Assert reset=0 mid-SEARCH (count_in=7) -> next edge state_out=0, lost=0, count_reset=1. Then a lost line from a post-reset FORWARD pivots left (last_dir reset value).
